// File: rtl/aes_pkg.sv
// Shared AES sequencing constants: key-length encodings, round counts and FSM states.
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;
    localparam logic [1:0] KEY_LEN_BAD = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Control/status bundle between a pass controller (master) and the round sequencer (slave).
interface aes_round_sequencer_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic [1:0]        key_len;
    logic              stall;
    logic              abort;
    logic [3:0]        round_num;
    logic [ADDR_W-1:0] round_key_addr;
    logic              wr;
    logic              busy;
    logic              last_round;
    logic              done;
    logic              err;

    modport master (
        output start, key_len, stall, abort,
        input  round_num, round_key_addr, wr, busy, last_round, done, err
    );

    modport slave (
        input  start, key_len, stall, abort,
        output round_num, round_key_addr, wr, busy, last_round, done, err
    );
endinterface

// File: rtl/aes_nr_decode.sv
// Maps key_len to the AES round count Nr and flags the reserved encoding.
module aes_nr_decode
    import aes_pkg::*;
(
    input  logic [1:0] key_len,
    output logic [3:0] nr,
    output logic       illegal
);

    always_comb begin
        nr      = NR_128;
        illegal = 1'b0;
        case (key_len)
            KEY_LEN_128: nr = NR_128;
            KEY_LEN_192: nr = NR_192;
            KEY_LEN_256: nr = NR_256;
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Steps round_num/round_key_addr through (Nr+1)*BEATS_PER_ROUND write beats per pass.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned BEATS_PER_ROUND = 16,
    parameter int unsigned ADDR_W          = $clog2(BEATS_PER_ROUND)
) (
    input  logic clk,
    input  logic rst,
    aes_round_sequencer_if.slave bus
);

    localparam int unsigned LAST_BEAT = BEATS_PER_ROUND - 1;

    seq_state_e        state;
    logic [3:0]        nr;
    logic [3:0]        round_num;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              last_round;
    logic              done;
    logic              err;

    logic [3:0]        dec_nr;
    logic              dec_illegal;

    aes_nr_decode u_nr_decode (
        .key_len (bus.key_len),
        .nr      (dec_nr),
        .illegal (dec_illegal)
    );

    // Sequencer FSM; status outputs are registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            nr         <= NR_128;
            round_num  <= 4'd0;
            addr       <= '0;
            busy       <= 1'b0;
            last_round <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (dec_illegal) begin
                            err <= 1'b1;
                        end else begin
                            state      <= ST_RUN;
                            nr         <= dec_nr;
                            round_num  <= 4'd0;
                            addr       <= '0;
                            busy       <= 1'b1;
                            last_round <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state      <= ST_IDLE;
                        round_num  <= 4'd0;
                        addr       <= '0;
                        busy       <= 1'b0;
                        last_round <= 1'b0;
                    end else if (!bus.stall) begin
                        if (addr == ADDR_W'(LAST_BEAT)) begin
                            if (round_num == nr) begin
                                state      <= ST_DONE;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                last_round <= 1'b0;
                            end else begin
                                round_num  <= round_num + 4'd1;
                                addr       <= '0;
                                last_round <= ((round_num + 4'd1) == nr);
                            end
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Final counter values are left visible in IDLE unless aborted.
                    state <= ST_IDLE;
                    if (bus.abort) begin
                        round_num <= 4'd0;
                        addr      <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr             = (state == ST_RUN) && !bus.stall;
    assign bus.round_num      = round_num;
    assign bus.round_key_addr = addr;
    assign bus.busy           = busy;
    assign bus.last_round     = last_round;
    assign bus.done           = done;
    assign bus.err            = err;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with BEATS_PER_ROUND=16.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_round_sequencer_if #(.ADDR_W(4)) bus ();

    aes_round_sequencer #(
        .BEATS_PER_ROUND (16),
        .ADDR_W          (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_round_num"}, int'(bus.round_num), 0);
        check({tag, "_addr"}, int'(bus.round_key_addr), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_err"}, int'(bus.err), 0);
        check({tag, "_last_round"}, int'(bus.last_round), 0);
        check({tag, "_wr"}, int'(bus.wr), 0);
    endtask

    // Launches one pass and tallies its beats; optional stall, abort and mid-pass start.
    task automatic run_pass(input string name, input logic [1:0] kl,
                            input bit do_stall, input bit do_abort, input bit mid_start,
                            output int wr_n, output int last_n, output int done_n,
                            output int done_cyc, output int max_rn, output int gap_n);
        int  stall_left;
        bit  stalled;
        bit  aborted;
        int  since_abort;
        wr_n = 0; last_n = 0; done_n = 0; done_cyc = -1; max_rn = 0; gap_n = 0;
        stall_left = 0; stalled = 1'b0; aborted = 1'b0; since_abort = 0;
        bus.key_len = kl;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            bus.stall = 1'b0;
            bus.abort = 1'b0;
            if (do_stall && !stalled && bus.busy && bus.round_num == 4'd3 && bus.round_key_addr == 4'd7) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                bus.stall = 1'b1;
                stall_left--;
            end
            if (do_abort && !aborted && bus.busy && bus.round_num == 4'd4 && bus.round_key_addr == 4'd9) begin
                bus.abort = 1'b1;
                aborted   = 1'b1;
            end
            if (mid_start) begin
                bus.start   = (cyc == 50);
                bus.key_len = (cyc == 50) ? 2'b10 : kl;
            end
            #1;
            if (bus.wr) wr_n++;
            if (bus.last_round) last_n++;
            if (bus.busy && !bus.wr) gap_n++;
            if (int'(bus.round_num) > max_rn) max_rn = int'(bus.round_num);
            if (bus.done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (aborted && since_abort == 1) begin
                check({name, "_post_abort_busy"}, int'(bus.busy), 0);
                check({name, "_post_abort_round"}, int'(bus.round_num), 0);
                check({name, "_post_abort_addr"}, int'(bus.round_key_addr), 0);
                check({name, "_post_abort_wr"}, int'(bus.wr), 0);
            end
            if (aborted) since_abort++;
            if (since_abort > 20) break;
            if (done_n > 0 && !bus.done) break;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        if (do_abort) check({name, "_abort_seen"}, int'(aborted), 1);
    endtask

    int wr_n, last_n, done_n, done_cyc, max_rn, gap_n;
    int done_cnt;

    initial begin
        bus.start   = 1'b0;
        bus.key_len = 2'b00;
        bus.stall   = 1'b0;
        bus.abort   = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // start together with abort in IDLE is ignored
        bus.start = 1'b1; bus.abort = 1'b1; bus.key_len = 2'b00;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_busy", int'(bus.busy), 0);
        check("start_abort_err", int'(bus.err), 0);

        // illegal key length
        bus.start = 1'b1; bus.key_len = 2'b11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("bad_key_err", int'(bus.err), 1);
        check("bad_key_busy", int'(bus.busy), 0);
        check("bad_key_wr", int'(bus.wr), 0);
        check("bad_key_round", int'(bus.round_num), 0);
        @(posedge clk); #1;
        check("bad_key_err_pulse", int'(bus.err), 0);
        check("bad_key_busy2", int'(bus.busy), 0);

        // AES-128 full pass
        run_pass("aes128", 2'b00, 1'b0, 1'b0, 1'b0, wr_n, last_n, done_n, done_cyc, max_rn, gap_n);
        check("aes128_wr", wr_n, 176);
        check("aes128_last", last_n, 16);
        check("aes128_done_n", done_n, 1);
        check("aes128_done_cyc", done_cyc, 177);
        check("aes128_max_round", max_rn, 10);
        check("aes128_gaps", gap_n, 0);
        check("aes128_hold_round", int'(bus.round_num), 10);
        check("aes128_hold_addr", int'(bus.round_key_addr), 15);
        check("aes128_idle_busy", int'(bus.busy), 0);

        // AES-256 and AES-192
        run_pass("aes256", 2'b10, 1'b0, 1'b0, 1'b0, wr_n, last_n, done_n, done_cyc, max_rn, gap_n);
        check("aes256_wr", wr_n, 240);
        check("aes256_last", last_n, 16);
        check("aes256_done_n", done_n, 1);
        check("aes256_max_round", max_rn, 14);
        run_pass("aes192", 2'b01, 1'b0, 1'b0, 1'b0, wr_n, last_n, done_n, done_cyc, max_rn, gap_n);
        check("aes192_wr", wr_n, 208);
        check("aes192_done_cyc", done_cyc, 209);
        check("aes192_max_round", max_rn, 12);

        // stall 5 cycles at round 3 addr 7
        run_pass("stall", 2'b00, 1'b1, 1'b0, 1'b0, wr_n, last_n, done_n, done_cyc, max_rn, gap_n);
        check("stall_wr", wr_n, 176);
        check("stall_gaps", gap_n, 5);
        check("stall_done_cyc", done_cyc, 182);

        // abort at round 4 addr 9, then a fresh full pass
        run_pass("abort", 2'b00, 1'b0, 1'b1, 1'b0, wr_n, last_n, done_n, done_cyc, max_rn, gap_n);
        check("abort_wr", wr_n, 74);
        check("abort_done_n", done_n, 0);
        check("abort_last", last_n, 0);
        run_pass("after_abort", 2'b00, 1'b0, 1'b0, 1'b0, wr_n, last_n, done_n, done_cyc, max_rn, gap_n);
        check("after_abort_wr", wr_n, 176);
        check("after_abort_done_n", done_n, 1);

        // start during RUN must not change Nr or the count
        run_pass("mid_start", 2'b00, 1'b0, 1'b0, 1'b1, wr_n, last_n, done_n, done_cyc, max_rn, gap_n);
        check("mid_start_wr", wr_n, 176);
        check("mid_start_done_cyc", done_cyc, 177);
        check("mid_start_max_round", max_rn, 10);

        // synchronous reset in the middle of a pass, with start held high
        bus.key_len = 2'b01; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("pre_rst_busy", int'(bus.busy), 1);
        bus.start = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("mid_rst");
        rst = 1'b0;
        bus.start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_idle_busy", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter BEATS_PER_ROUND, default 16, round-key words/bytes written per round; legal range 2..256.
REQ-002 SHALL have parameter ADDR_W, default $clog2(BEATS_PER_ROUND), round_key_addr width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  begin a key schedule/encryption pass; sampled only in IDLE.
REQ-007 key_len  in  2  00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=illegal; sampled with start.
REQ-008 stall  in  1  freeze counters for this cycle.
REQ-009 abort  in  1  terminate pass, return to IDLE.
REQ-010 round_num  out  4  current round, 0..Nr.
REQ-011 round_key_addr  out  ADDR_W  beat index within round.
REQ-012 wr  out  1  write strobe for round_key_addr/round_num.
REQ-013 busy  out  1  high in RUN.
REQ-014 last_round  out  1  high in RUN while round_num==Nr.
REQ-015 done  out  1  one-cycle pulse, pass completed.
REQ-016 err  out  1  one-cycle pulse, start with key_len=11.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: start=1, abort=0, key_len legal -> next cycle RUN, Nr latched, round_num=0, round_key_addr=0.
REQ-019 IDLE: start=1, key_len=11, abort=0 -> stay IDLE, err=1 next cycle for one cycle, counters unchanged.
REQ-020 RUN, stall=0: wr=1 (combinational, state==RUN && !stall); round_key_addr increments by 1 each cycle.
REQ-021 RUN, stall=0, round_key_addr==BEATS_PER_ROUND-1, round_num<Nr: round_key_addr wraps to 0, round_num+1, no gap cycle (wr stays high).
REQ-022 RUN, stall=0, round_key_addr==BEATS_PER_ROUND-1, round_num==Nr: next state DONE.
REQ-023 RUN, stall=1: wr=0, all counters and state hold.
REQ-024 DONE: done=1, busy=0, wr=0 for exactly one cycle, then IDLE; round_num and round_key_addr hold final values (Nr, BEATS_PER_ROUND-1) until next accepted start.
REQ-025 Pass length: exactly (Nr+1)*BEATS_PER_ROUND wr cycles, excluding stalls.
REQ-026 abort=1 in RUN or DONE: next cycle IDLE, round_num=0, round_key_addr=0, no done pulse; abort beats stall and start.
REQ-027 start in RUN or DONE SHALL be ignored; Nr SHALL not change mid-pass.
REQ-028 start and abort together in IDLE: start ignored, no err.
REQ-029 Counter arithmetic modulo width; round_num never exceeds Nr.

Reset
REQ-030 rst=1 at clock edge: state IDLE, round_num=0, round_key_addr=0, Nr=10, busy=0, done=0, err=0, last_round=0, wr=0.
REQ-031 rst has priority over all inputs, including mid-pass; no done after reset-abort.

Structure
REQ-032 Shared package aes_pkg SHALL hold key_len encoding constants, Nr constants (10/12/14) and FSM state typedef.
REQ-033 One sub-module aes_nr_decode (key_len -> Nr, illegal flag), combinational.
REQ-034 All outputs except wr registered; wr from registered state and stall only.

Verification (BEATS_PER_ROUND=16)
REQ-035 start, key_len=00 at cycle 0 -> wr high cycles 1..176, round_num 0..10, done at cycle 177 only.
REQ-036 key_len=10 -> 240 wr cycles, last_round high for final 16, done once; key_len=01 -> 208 wr cycles.
REQ-037 stall=1 for 5 cycles at round 3, addr 7 -> counters frozen, wr low 5 cycles, done delayed by 5.
REQ-038 abort at round 4 addr 9 -> next cycle IDLE, round_num=0, no done; new start runs full pass.
REQ-039 start with key_len=11 -> err pulse one cycle, busy stays 0, no wr.
REQ-040 rst asserted mid-pass, start during RUN -> reset values next cycle; mid-pass start no effect on count.
